// File: rtl/conway_pkg.sv
// Shared definitions for the Game-of-Life control stage and grid wrapper.
package conway_pkg;

  typedef enum logic [2:0] {
    LOAD,
    APPLY,
    IDLE,
    RUN,
    HOLD
  } ctrl_state_t;

  localparam int DEF_ROWS = 8;
  localparam int DEF_COLS = 8;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conway_tick_gen.sv
// Generation tick counter: counts 0..TICKS-1 while run is high, flags the last count.
module conway_tick_gen
  import conway_pkg::*;
#(
  parameter int TICKS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic terminal
);

  localparam int CW = cnt_width(TICKS);
  localparam logic [CW-1:0] LAST = CW'(TICKS - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      if (count == LAST) count <= '0;
      else               count <= count + 1'b1;
    end
  end

  assign terminal = run && (count == LAST);

endmodule

// File: rtl/conway_controller.sv
// Control stage for the cell array: serial seed loading, load strobe and
// generation-advance strobe (free-run or single-step).
module conway_controller
  import conway_pkg::*;
#(
  parameter int ROWS  = DEF_ROWS,
  parameter int COLS  = DEF_COLS,
  parameter int TICKS = 4,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 seed_bit,
  input  logic                 seed_valid,
  output logic                 seed_ready,
  input  logic                 start,
  input  logic                 pause,
  input  logic                 step,
  input  logic                 reload,
  output logic [ROWS*COLS-1:0] state_0,
  output logic                 cell_rst,
  output logic                 cell_ena,
  output logic [GEN_W-1:0]     generation,
  output logic                 running
);

  localparam int N  = ROWS * COLS;
  localparam int BW = cnt_width(N);
  localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

  ctrl_state_t state, next_state;

  logic [BW-1:0] bit_cnt;
  logic          step_prev;
  logic          step_rise;
  logic          seed_fire;
  logic          tick_run;
  logic          tick_clear;
  logic          terminal;
  logic          ena_next;
  logic          gen_inc;

  assign seed_ready = (state == LOAD);
  assign cell_rst   = (state == LOAD) || (state == APPLY);
  assign running    = (state == RUN);
  assign seed_fire  = seed_valid && seed_ready;
  assign step_rise  = step && !step_prev;

  conway_tick_gen #(
    .TICKS(TICKS)
  ) u_tick (
    .clk     (clk),
    .rst     (rst),
    .run     (tick_run),
    .clear   (tick_clear),
    .terminal(terminal)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= LOAD;
      step_prev <= 1'b0;
      cell_ena  <= 1'b0;
    end else begin
      state     <= next_state;
      step_prev <= step;
      cell_ena  <= ena_next;
    end
  end

  // The edge that enters RUN from IDLE already counts as the first tick,
  // so the first pulse follows TICKS-1 edges after start is seen.
  always_comb begin
    next_state = state;
    tick_run   = 1'b0;
    tick_clear = 1'b0;
    ena_next   = 1'b0;
    gen_inc    = 1'b0;
    case (state)
      LOAD: begin
        if (seed_fire && (bit_cnt == LAST_BIT)) next_state = APPLY;
      end
      APPLY: begin
        tick_clear = 1'b1;
        next_state = reload ? LOAD : IDLE;
      end
      IDLE: begin
        if (reload) begin
          next_state = LOAD;
          tick_clear = 1'b1;
        end else if (start) begin
          next_state = RUN;
          tick_run   = 1'b1;
        end
      end
      RUN: begin
        if (reload) begin
          next_state = LOAD;
          tick_clear = 1'b1;
        end else begin
          tick_run = 1'b1;
          if (terminal) begin
            ena_next = 1'b1;
            gen_inc  = 1'b1;
          end
          if (pause) next_state = HOLD;
        end
      end
      HOLD: begin
        if (reload) begin
          next_state = LOAD;
          tick_clear = 1'b1;
        end else if (!pause && start) begin
          next_state = RUN;
        end else if (step_rise) begin
          ena_next = 1'b1;
          gen_inc  = 1'b1;
        end
      end
      default: next_state = LOAD;
    endcase
  end

  // Seed bits land at their final index as they arrive; untouched bits keep
  // whatever the previous pattern left there.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_0 <= '0;
      bit_cnt <= '0;
    end else if (seed_fire) begin
      state_0[bit_cnt] <= seed_bit;
      bit_cnt          <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
    end else if ((next_state == LOAD) && (state != LOAD)) begin
      bit_cnt <= '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      generation <= '0;
    end else if (state == APPLY) begin
      generation <= '0;
    end else if (gen_inc) begin
      generation <= generation + 1'b1;
    end
  end

endmodule

// File: doc/conway_controller.md
Name: conway_controller

Overview:
- Upstream control stage for the Game-of-Life cell array.
- Accepts a serial seed pattern over a valid/ready stream and assembles the ROWS*COLS initial-state vector (state_0) for the cells.
- Drives the cells' load strobe (cell_rst) and their generation-advance strobe (cell_ena): free-running at a programmable tick period, or single-stepped while paused.
- Sits between the board I/O (buttons, UART/shift input) and the cell grid.

Parameters:
ROWS, 8, grid rows
COLS, 8, grid columns
TICKS, 4, clock cycles per generation in free-run (>=2)
GEN_W, 16, generation counter width

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset (0 = reset)
seed_bit  input  1  serial seed data
seed_valid  input  1  seed_bit is valid this cycle
seed_ready  output  1  controller accepts seed bits
start  input  1  level; enter/resume free-run
pause  input  1  level; suspend free-run
step  input  1  single-step request; acts on rising edge only
reload  input  1  level; abandon current run, reload seed
state_0  output  ROWS*COLS  initial state vector, index = row*COLS+col
cell_rst  output  1  active-high load strobe to every cell
cell_ena  output  1  active-high one-cycle generation advance to every cell
generation  output  GEN_W  generations advanced since last load
running  output  1  high in RUN

Behaviour:
- States:
  - LOAD: shift in seed bits.
  - APPLY: one cycle.
  - IDLE: loaded, waiting for start.
  - RUN: free-run.
  - HOLD: paused.
- Values while rst=0 and after reset:
  - State LOAD; bit count 0; state_0 all 0; generation 0; tick count 0.
  - cell_ena 0; cell_rst 1; seed_ready 1; running 0; step edge register 0.
- Moore outputs:
  - cell_rst = 1 in LOAD and APPLY.
  - seed_ready = 1 only in LOAD.
  - running = 1 only in RUN.
- LOAD:
  - A transfer occurs on an edge with seed_valid & seed_ready.
  - The k-th accepted bit (k from 0) is written to state_0[k]; other bits are unchanged.
  - Bits not yet rewritten keep their prior value.
  - On the edge accepting bit N-1 (N = ROWS*COLS): go to APPLY, clear the count.
  - seed_valid while not in LOAD is ignored.
- APPLY:
  - cell_rst = 1 for exactly one cycle, so the cells sample the final state_0.
  - generation cleared to 0.
  - Next state IDLE.
- IDLE: start = 1 → RUN with tick count 0. pause and step are ignored.
- RUN:
  - Tick count increments every edge.
  - On the edge where count == TICKS-1: count ← 0, cell_ena ← 1 for the next cycle only, generation ← generation+1 (wraps modulo 2^GEN_W).
  - Otherwise cell_ena ← 0.
  - First pulse is high during the cycle after edge E0+TICKS-1, where E0 is the edge that entered RUN. The pulse period is exactly TICKS.
  - pause = 1 → HOLD, tick count frozen. If the terminal tick coincides with pause, the pulse is still issued and the state becomes HOLD.
- HOLD:
  - A step rising edge (step & ~step_prev) → cell_ena ← 1 for one cycle, generation++.
  - Holding step high gives exactly one pulse.
  - start = 1 and pause = 0 → RUN, resuming the frozen tick count.
- Input priority on any edge: reload > pause > start > step.
- reload = 1 in IDLE, RUN, HOLD or APPLY:
  - Next state LOAD; bit count 0; tick count 0; cell_ena ← 0.
  - state_0 is retained until overwritten. generation is held until APPLY.
- cell_rst and cell_ena are never high in the same cycle.
- generation changes only on the edge that raises cell_ena, and in APPLY.

Decomposition:
- Shared package conway_pkg:
  - ctrl_state_t enum {LOAD, APPLY, IDLE, RUN, HOLD}.
  - Grid-size defaults ROWS/COLS, so that the grid wrapper and this block agree.
- One natural sub-module, conway_tick_gen:
  - Parameterised TICKS counter with enable (run), clear, and a one-cycle terminal pulse.
  - Synchronous active-low rst.

Test Plan:
- Reset then 64 seed bits (ROWS=COLS=8) with glider pattern, seed_valid gapped every 3rd cycle → state_0 matches the pattern bit-for-bit; APPLY gives exactly one extra cell_rst cycle; seed_ready drops after bit 63; generation=0.
- IDLE, start=1 at edge E0, TICKS=4 → cell_ena high only in cycles after E0+3, E0+7, E0+11; generation reads 1, 2, 3 at those pulses; cell_rst stays 0.
- RUN, pause asserted on the same edge as the terminal tick → that pulse still issued; no further pulses for 20 cycles; generation frozen.
- HOLD, step held high for 5 cycles, then low, then high → exactly 2 cell_ena pulses; generation +2.
- RUN with reload=1 and start=1 simultaneously → LOAD next cycle; seed_ready=1; cell_rst=1; cell_ena=0; reload a new 64-bit pattern, then after APPLY generation=0.
- rst=0 asserted mid-LOAD after 30 bits → next cycle state_0 = 0, bit count 0; a full 64-bit reload succeeds.
